// File: rtl/dmem_pkg.sv
// dmem_pkg: shared types for the data-memory controller.
//   size_e  : access size encodings on Size_i
//   state_e : controller FSM states
//   req_t   : one latched load/store request
//   WCNT_W  : width of the wait-state counter
package dmem_pkg;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'b00,
    SZ_HALF = 2'b01,
    SZ_WORD = 2'b10,
    SZ_RSVD = 2'b11
  } size_e;

  typedef enum logic [1:0] {
    ST_INIT,
    ST_IDLE,
    ST_WAIT,
    ST_RESP
  } state_e;

  localparam int WCNT_W = 4;

  typedef struct packed {
    logic        we;
    size_e       size;
    logic        sign;
    logic [31:0] addr;
    logic [31:0] data;
  } req_t;

  // Size/alignment part of the fault check; the range check lives in the top.
  function automatic logic bad_align(size_e s, logic [1:0] a);
    case (s)
      SZ_BYTE: bad_align = 1'b0;
      SZ_HALF: bad_align = a[0];
      SZ_WORD: bad_align = |a;
      default: bad_align = 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/dmem_lane_align.sv
// dmem_lane_align: byte-lane steering between the 32-bit memory word and the
// LSB-aligned request data.
//   size_i/sign_i/addr_i : access size, sign-extend flag, low address bits
//   wdata_i  -> wdata_o  : store data replicated onto every candidate lane
//   be_o                 : byte-lane write enables
//   rword_i  -> rdata_o  : selected lanes moved to LSBs and extended
module dmem_lane_align
  import dmem_pkg::*;
(
  input  size_e       size_i,
  input  logic        sign_i,
  input  logic [1:0]  addr_i,
  input  logic [31:0] wdata_i,
  input  logic [31:0] rword_i,
  output logic [3:0]  be_o,
  output logic [31:0] wdata_o,
  output logic [31:0] rdata_o
);

  logic [7:0]  b;
  logic [15:0] h;

  always_comb begin
    b       = rword_i[{addr_i, 3'b000} +: 8];
    h       = addr_i[1] ? rword_i[31:16] : rword_i[15:0];
    be_o    = 4'b0000;
    wdata_o = 32'h0;
    rdata_o = 32'h0;
    case (size_i)
      SZ_BYTE: begin
        be_o    = 4'b0001 << addr_i;
        wdata_o = {4{wdata_i[7:0]}};
        rdata_o = {{24{sign_i & b[7]}}, b};
      end
      SZ_HALF: begin
        be_o    = addr_i[1] ? 4'b1100 : 4'b0011;
        wdata_o = {2{wdata_i[15:0]}};
        rdata_o = {{16{sign_i & h[15]}}, h};
      end
      SZ_WORD: begin
        be_o    = 4'b1111;
        wdata_o = wdata_i;
        rdata_o = rword_i;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/dmem_ctrl.sv
// dmem_ctrl: single-port data memory with byte/half/word access, a fixed
// number of wait states and a self-clearing power-up sequence.
//   clk, rst                : clock, synchronous active-high reset
//   Req_i/Accept_o          : request handshake (accepted only in IDLE)
//   We_i/Size_i/Sign_i      : store/load, access size, sign-extend loads
//   Addr_i/DataIn_i         : byte address, LSB-aligned store data
//   Ready_o/DataOut_o/Fault_o : one-cycle response, load data, rejection
//   InitBusy_o              : memory clear in progress
module dmem_ctrl
  import dmem_pkg::*;
#(
  parameter int DEPTH_WORDS = 1024,
  parameter int WAIT_STATES = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        Req_i,
  input  logic        We_i,
  input  logic [1:0]  Size_i,
  input  logic        Sign_i,
  input  logic [31:0] Addr_i,
  input  logic [31:0] DataIn_i,
  output logic        Accept_o,
  output logic        Ready_o,
  output logic [31:0] DataOut_o,
  output logic        Fault_o,
  output logic        InitBusy_o
);

  localparam int AW = $clog2(DEPTH_WORDS);

  logic [31:0]       mem [DEPTH_WORDS];
  state_e            state_q;
  logic [AW-1:0]     idx_q;
  logic [WCNT_W-1:0] cnt_q;
  req_t              req_q;
  logic              ready_q, fault_q;
  logic [31:0]       dout_q;

  req_t              req_live, src;
  logic [AW-1:0]     widx;
  logic              fault_d;
  logic [3:0]        be;
  logic [31:0]       wdata_al, rdata_al, dout_d;

  assign req_live = '{we: We_i, size: size_e'(Size_i), sign: Sign_i,
                      addr: Addr_i, data: DataIn_i};

  // In IDLE the response may be formed at the accept edge (WAIT_STATES=0),
  // so lane logic looks at the live request there and at the latched one
  // otherwise.
  assign src  = (state_q == ST_IDLE) ? req_live : req_q;
  assign widx = src.addr[AW+1:2];

  assign fault_d = bad_align(src.size, src.addr[1:0]) |
                   (src.addr[31:2] >= 30'(DEPTH_WORDS));

  dmem_lane_align u_align (
    .size_i  (src.size),
    .sign_i  (src.sign),
    .addr_i  (src.addr[1:0]),
    .wdata_i (src.data),
    .rword_i (mem[widx]),
    .be_o    (be),
    .wdata_o (wdata_al),
    .rdata_o (rdata_al)
  );

  assign dout_d = (fault_d || src.we) ? 32'h0 : rdata_al;

  assign Accept_o   = (state_q == ST_IDLE) && Req_i;
  assign Ready_o    = ready_q;
  assign Fault_o    = fault_q;
  assign DataOut_o  = dout_q;
  assign InitBusy_o = (state_q == ST_INIT);

  // Memory array: clearing during INIT, store commit on the RESP edge.
  // Nothing is written while rst is high, which aborts pending stores.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (state_q == ST_INIT) begin
        mem[idx_q] <= 32'h0;
      end else if (state_q == ST_RESP && req_q.we && !fault_d) begin
        for (int i = 0; i < 4; i++)
          if (be[i]) mem[widx][8*i +: 8] <= wdata_al[8*i +: 8];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_INIT;
      idx_q   <= '0;
      cnt_q   <= '0;
      req_q   <= '0;
      ready_q <= 1'b0;
      fault_q <= 1'b0;
      dout_q  <= 32'h0;
    end else begin
      ready_q <= 1'b0;
      fault_q <= 1'b0;
      case (state_q)
        ST_INIT: begin
          idx_q <= idx_q + 1'b1;
          if (idx_q == AW'(DEPTH_WORDS - 1)) state_q <= ST_IDLE;
        end
        ST_IDLE: begin
          if (Req_i) begin
            req_q <= req_live;
            cnt_q <= '0;
            if (WAIT_STATES == 0) begin
              state_q <= ST_RESP;
              ready_q <= 1'b1;
              fault_q <= fault_d;
              dout_q  <= dout_d;
            end else begin
              state_q <= ST_WAIT;
            end
          end
        end
        ST_WAIT: begin
          if (cnt_q == WCNT_W'(WAIT_STATES - 1)) begin
            state_q <= ST_RESP;
            ready_q <= 1'b1;
            fault_q <= fault_d;
            dout_q  <= dout_d;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        ST_RESP: state_q <= ST_IDLE;
        default: state_q <= ST_INIT;
      endcase
    end
  end

endmodule

// File: doc/dmem_ctrl.md
DMEM_CTRL -- requirements
Module: dmem_ctrl

Interface
REQ-001 SHALL have parameter DEPTH_WORDS, default 1024: number of 32-bit words; power of 2, minimum 4.
REQ-002 SHALL have parameter WAIT_STATES, default 1: extra cycles between accept and response; range 0..15.
REQ-003 SHALL have port clk, input, 1: sole clock, rising edge.
REQ-004 SHALL have port rst, input, 1: one clock; reset is synchronous and active-high.
REQ-005 SHALL have port Req_i, input, 1: request valid.
REQ-006 SHALL have port We_i, input, 1: 1 = store, 0 = load.
REQ-007 SHALL have port Size_i, input, 2: 00 = byte, 01 = half, 10 = word, 11 = reserved.
REQ-008 SHALL have port Sign_i, input, 1: sign-extend byte and half loads.
REQ-009 SHALL have port Addr_i, input, 32: byte address.
REQ-010 SHALL have port DataIn_i, input, 32: store data, LSB-aligned.
REQ-011 SHALL have port Accept_o, output, 1: request accepted this cycle.
REQ-012 SHALL have port Ready_o, output, 1: response valid, single-cycle pulse.
REQ-013 SHALL have port DataOut_o, output, 32: load data, held until the next response.
REQ-014 SHALL have port Fault_o, output, 1: qualified by Ready_o; access rejected.
REQ-015 SHALL have port InitBusy_o, output, 1: memory clear in progress.

Function
REQ-016 FSM SHALL have states INIT, IDLE, WAIT and RESP.
REQ-017 INIT SHALL zero one word per cycle, indices 0 to DEPTH_WORDS-1, then go to IDLE; InitBusy_o = 1 and Accept_o = 0 throughout.
REQ-018 Accept_o SHALL equal Req_i in IDLE only; on accept, latch Addr_i, We_i, Size_i, Sign_i and DataIn_i; next state is WAIT if WAIT_STATES > 0, else RESP.
REQ-019 WAIT SHALL last exactly WAIT_STATES cycles, counted by a 4-bit counter, then go to RESP.
REQ-020 RESP SHALL pulse Ready_o for one cycle, commit any store at that edge, then return to IDLE.
REQ-021 Latency: a request accepted in cycle N SHALL produce Ready_o in cycle N+1+WAIT_STATES.
REQ-022 Req_i outside IDLE SHALL be ignored; the requester holds Req_i until Accept_o.
REQ-023 Store lanes SHALL be: byte writes lane Addr[1:0] from DataIn_i[7:0]; half writes lanes 1:0 (Addr[1]=0) or lanes 3:2 (Addr[1]=1) from DataIn_i[15:0]; word writes all lanes; other lanes unchanged.
REQ-024 Load lanes SHALL be selected the same way, moved to bits [7:0] or [15:0], and zero- or sign-extended per Sign_i; word loads ignore Sign_i.
REQ-025 Fault SHALL occur on: half with Addr[0]=1; word with Addr[1:0] != 0; Size_i = 11; or Addr[31:2] >= DEPTH_WORDS.
REQ-026 A faulted access SHALL perform no write and return DataOut_o = 0 with Fault_o = 1 during Ready_o.
REQ-027 A load following a store to the same word SHALL return the stored value, with no stall.
REQ-028 Fault_o SHALL be 0 whenever Ready_o = 0.

Reset
REQ-029 While rst = 1 and in the cycle after: state INIT, clear index 0, wait counter 0, Accept_o 0, Ready_o 0, Fault_o 0, DataOut_o 0, InitBusy_o 1.
REQ-030 rst during WAIT or RESP SHALL abort the transaction with no memory write; rst during INIT SHALL restart clearing from index 0.

Structure
REQ-031 Package dmem_pkg SHALL hold the Size_i encodings, the FSM state enum and the WAIT_STATES counter width.
REQ-032 Sub-module dmem_lane_align SHALL contain the combinational write-lane mask, store data replication and load extract/extend logic.

Verification (DEPTH_WORDS=1024, WAIT_STATES=1 unless stated)
REQ-033 After reset: InitBusy_o high for exactly 1024 cycles; word load at 0x10 returns 0x00000000.
REQ-034 Store word 0x8899AABB at 0x20, then: byte load 0x23 signed -> 0xFFFFFF88; byte 0x22 unsigned -> 0x00000099; half 0x22 signed -> 0xFFFF8899; half 0x20 unsigned -> 0x0000AABB.
REQ-035 Store byte 0x5A at 0x21, then word load at 0x20 -> 0x88995ABB.
REQ-036 Word load at 0x22 -> Fault_o=1, DataOut_o=0; word store at 0x1000 -> Fault_o=1, and all words read back unchanged.
REQ-037 With WAIT_STATES=0 and WAIT_STATES=3: Ready_o at N+1 and N+4 respectively; Req_i held during WAIT gets no Accept_o until IDLE.
REQ-038 Assert rst during WAIT of a word store of 0xDEADBEEF to 0x40 -> after re-init, word load at 0x40 returns 0x00000000.
